// File: rtl/swipt_pkg.sv
// rtl/swipt_pkg.sv - shared state encoding and default timing constants for the sweep sequencer
package swipt_pkg;

  // Sequencer states
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_APPLY   = 3'd1;
  localparam logic [2:0] ST_SETTLE  = 3'd2;
  localparam logic [2:0] ST_MEASURE = 3'd3;
  localparam logic [2:0] ST_REPORT  = 3'd4;
  localparam logic [2:0] ST_BLANK   = 3'd5;

  // Default timing at 100 MHz
  localparam int DEF_SETTLE_CYCLES = 100000000;
  localparam int DEF_WIN_CYCLES    = 1024;
  localparam int DEF_BLANK_CYCLES  = 800000;

  // Width of the shared phase timer; wide enough for the one-second settle
  localparam int TIMER_W = 32;

  // Most-negative envelope value for the default 12-bit detector
  localparam int DEF_AMP_W = 12;
  localparam logic signed [DEF_AMP_W-1:0] AMP_MIN = {1'b1, {(DEF_AMP_W-1){1'b0}}};

endpackage

// File: rtl/swipt_cycle_timer.sv
// rtl/swipt_cycle_timer.sv - loadable down-counter shared by the timed sequencer phases
module swipt_cycle_timer
  import swipt_pkg::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  // Load on phase entry with (length - 1); count down and park at zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // done marks the final cycle of the loaded phase
  assign done = (count == '0);

endmodule

// File: rtl/swipt_sweep_sequencer.sv
// rtl/swipt_sweep_sequencer.sv - steps the SWIPT TX through a frequency sweep and reports envelope peaks
module swipt_sweep_sequencer
  import swipt_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int WIN_CYCLES    = DEF_WIN_CYCLES,
  parameter int BLANK_CYCLES  = DEF_BLANK_CYCLES,
  parameter int FREQ_W        = 32,
  parameter int AMP_W         = DEF_AMP_W
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_start,
  input  logic                     i_abort,
  input  logic [FREQ_W-1:0]        i_freq_base,
  input  logic [FREQ_W-1:0]        i_freq_step,
  input  logic [4:0]               i_n_points,
  input  logic signed [AMP_W-1:0]  i_envelope_max,
  output logic [FREQ_W-1:0]        o_freq,
  output logic                     o_enable,
  output logic                     o_busy,
  output logic                     o_res_valid,
  input  logic                     i_res_ready,
  output logic [FREQ_W-1:0]        o_res_freq,
  output logic signed [AMP_W-1:0]  o_res_amp,
  output logic                     o_res_last,
  output logic                     o_done
);

  // Timer holds (length - 1) so the phase lasts exactly its programmed length
  localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WIN_LOAD    = TIMER_W'(WIN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] BLANK_LOAD  = TIMER_W'(BLANK_CYCLES - 1);
  localparam logic signed [AMP_W-1:0] AMP_LOW = {1'b1, {(AMP_W-1){1'b0}}};

  logic [2:0]               state;
  logic [FREQ_W-1:0]        freq_acc;
  logic [FREQ_W-1:0]        freq_step;
  logic [4:0]               last_idx;
  logic [4:0]               point_idx;
  logic signed [AMP_W-1:0]  run_max;
  logic signed [AMP_W-1:0]  win_peak;
  logic                     timer_load;
  logic [TIMER_W-1:0]       timer_val;
  logic                     timer_done;

  swipt_cycle_timer #(.W(TIMER_W)) u_timer (
    .clk      (i_clk),
    .rst_n    (i_nrst),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Peak including the current sample, used on the final window cycle
  assign win_peak = (i_envelope_max > run_max) ? i_envelope_max : run_max;

  // Reload the shared timer on the cycle before each timed phase begins
  always_comb begin
    timer_load = 1'b0;
    timer_val  = SETTLE_LOAD;
    case (state)
      ST_APPLY: begin
        timer_load = 1'b1;
        timer_val  = SETTLE_LOAD;
      end
      ST_SETTLE: begin
        timer_load = timer_done;
        timer_val  = WIN_LOAD;
      end
      ST_REPORT: begin
        timer_load = i_res_ready;
        timer_val  = BLANK_LOAD;
      end
      default: begin
        timer_load = 1'b0;
        timer_val  = SETTLE_LOAD;
      end
    endcase
  end

  // Sweep sequencing, measurement and result handshake
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state       <= ST_IDLE;
      freq_acc    <= '0;
      freq_step   <= '0;
      last_idx    <= '0;
      point_idx   <= '0;
      run_max     <= AMP_LOW;
      o_freq      <= '0;
      o_enable    <= 1'b1;
      o_busy      <= 1'b0;
      o_res_valid <= 1'b0;
      o_res_freq  <= '0;
      o_res_amp   <= '0;
      o_res_last  <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (i_abort && (state != ST_IDLE)) begin
        // Abort beats a simultaneous ready; the result is simply dropped
        state       <= ST_IDLE;
        o_res_valid <= 1'b0;
        o_enable    <= 1'b1;
        o_busy      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              freq_acc  <= i_freq_base;
              freq_step <= i_freq_step;
              last_idx  <= (i_n_points == 5'd0) ? 5'd0 : (i_n_points - 5'd1);
              point_idx <= '0;
              o_busy    <= 1'b1;
              state     <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            o_freq   <= freq_acc;
            freq_acc <= freq_acc + freq_step;
            state    <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (timer_done) begin
              run_max <= AMP_LOW;
              state   <= ST_MEASURE;
            end
          end
          ST_MEASURE: begin
            run_max <= win_peak;
            if (timer_done) begin
              o_res_amp   <= win_peak;
              o_res_freq  <= o_freq;
              o_res_last  <= (point_idx == last_idx);
              o_res_valid <= 1'b1;
              state       <= ST_REPORT;
            end
          end
          ST_REPORT: begin
            if (i_res_ready) begin
              o_res_valid <= 1'b0;
              o_enable    <= 1'b0;
              state       <= ST_BLANK;
            end
          end
          ST_BLANK: begin
            if (timer_done) begin
              o_enable <= 1'b1;
              if (point_idx == last_idx) begin
                o_done <= 1'b1;
                o_busy <= 1'b0;
                state  <= ST_IDLE;
              end else begin
                point_idx <= point_idx + 5'd1;
                state     <= ST_APPLY;
              end
            end
          end
          default: begin
            o_enable <= 1'b1;
            o_busy   <= 1'b0;
            state    <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_swipt_sweep_sequencer.sv
// tb/tb_swipt_sweep_sequencer.sv - scoreboard bench for the sweep sequencer
module tb_swipt_sweep_sequencer;

  localparam int SET = 4;
  localparam int WIN = 2;
  localparam int BLK = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [31:0]        base = '0;
  logic [31:0]        step = '0;
  logic [4:0]         npts = '0;
  logic signed [11:0] env = '0;
  logic               ready = 1'b1;
  logic [31:0]        freq;
  logic               enable;
  logic               busy;
  logic               res_valid;
  logic [31:0]        res_freq;
  logic signed [11:0] res_amp;
  logic               res_last;
  logic               done;

  swipt_sweep_sequencer #(
    .SETTLE_CYCLES(SET), .WIN_CYCLES(WIN), .BLANK_CYCLES(BLK), .FREQ_W(32), .AMP_W(12)
  ) dut (
    .i_clk(clk), .i_nrst(rst_n), .i_start(start), .i_abort(abort),
    .i_freq_base(base), .i_freq_step(step), .i_n_points(npts), .i_envelope_max(env),
    .o_freq(freq), .o_enable(enable), .o_busy(busy), .o_res_valid(res_valid),
    .i_res_ready(ready), .o_res_freq(res_freq), .o_res_amp(res_amp),
    .o_res_last(res_last), .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]        f;
    logic signed [11:0] a;
    logic               l;
  } res_t;

  res_t q[$];
  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  int done_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted result and checks held fields while stalled
  logic [31:0]        pf;
  logic signed [11:0] pa;
  logic               pl;
  bit                 stalled = 0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_seen++;
      if (res_valid) begin
        chk("enable_in_report", {63'd0, enable}, 64'd1);
        if (stalled) begin
          chk("stall_freq", {32'd0, res_freq}, {32'd0, pf});
          chk("stall_amp", {52'd0, res_amp}, {52'd0, pa});
          chk("stall_last", {63'd0, res_last}, {63'd0, pl});
        end
        if (ready) begin
          if (q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_result: got freq %0h with empty scoreboard", res_freq);
          end else begin
            res_t e;
            e = q.pop_front();
            chk("res_freq", {32'd0, res_freq}, {32'd0, e.f});
            chk("res_amp", {52'd0, res_amp}, {52'd0, e.a});
            chk("res_last", {63'd0, res_last}, {63'd0, e.l});
          end
          stalled = 0;
        end else begin
          stalled = 1;
          pf = res_freq;
          pa = res_amp;
          pl = res_last;
        end
      end else begin
        stalled = 0;
      end
    end else begin
      stalled = 0;
    end
  end

  logic signed [11:0] dw0, dw1;

  // Runs one sweep on the spec timeline; optional directed window, stall, busy-start poke, mid-blank reset
  task automatic run_sweep(input logic [31:0] b, input logic [31:0] s, input logic [4:0] nn,
                           input int stall, input bit directed, input bit poke, input bit rst_blank);
    int ne;
    logic signed [11:0] w0, w1;
    res_t e;
    ne = (nn == 5'd0) ? 1 : int'(nn);
    base = b; step = s; npts = nn; ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base = $urandom; step = $urandom; npts = 5'($urandom);
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    for (int i = 0; i < ne; i++) begin
      w0 = directed ? dw0 : 12'($urandom);
      w1 = directed ? dw1 : 12'($urandom);
      @(posedge clk); #1;
      e.f = b + s * 32'(i);
      chk("nco_freq", {32'd0, freq}, {32'd0, e.f});
      for (int k = 0; k < SET; k++) begin
        if (k == 0 && poke && i == 0) start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      env = w0;
      @(posedge clk); #1;
      env = w1;
      if (stall > 0) ready = 1'b0;
      e.a = (w0 > w1) ? w0 : w1;
      e.l = (i == ne - 1);
      q.push_back(e);
      @(posedge clk); #1;
      env = 12'($urandom);
      chk("valid_rises", {63'd0, res_valid}, 64'd1);
      repeat (stall) begin
        @(posedge clk); #1;
      end
      ready = 1'b1;
      @(posedge clk); #1;
      chk("valid_drops", {63'd0, res_valid}, 64'd0);
      chk("blank_enable", {63'd0, enable}, 64'd0);
      if (rst_blank) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_freq", {32'd0, freq}, 64'd0);
        chk("rst_enable", {63'd0, enable}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_valid", {63'd0, res_valid}, 64'd0);
        chk("rst_res_freq", {32'd0, res_freq}, 64'd0);
        chk("rst_res_amp", {52'd0, res_amp}, 64'd0);
        chk("rst_res_last", {63'd0, res_last}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        return;
      end
      for (int k = 1; k < BLK; k++) begin
        @(posedge clk); #1;
        chk("blank_enable", {63'd0, enable}, 64'd0);
      end
      @(posedge clk); #1;
      chk("enable_restored", {63'd0, enable}, 64'd1);
      if (i == ne - 1) begin
        chk("done_pulse", {63'd0, done}, 64'd1);
        chk("idle_busy", {63'd0, busy}, 64'd0);
        done_exp++;
      end else begin
        chk("no_early_done", {63'd0, done}, 64'd0);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_freq", {32'd0, freq}, 64'd0);
    chk("reset_enable", {63'd0, enable}, 64'd1);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_valid", {63'd0, res_valid}, 64'd0);
    chk("reset_res_freq", {32'd0, res_freq}, 64'd0);
    chk("reset_res_amp", {52'd0, res_amp}, 64'd0);
    chk("reset_res_last", {63'd0, res_last}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_sweep(32'd1000, 32'd10, 5'd3, 0, 0, 0, 0);
    run_sweep(32'h1234, 32'd7, 5'd2, 5, 0, 0, 0);
    dw0 = -12'sd5; dw1 = -12'sd3;
    run_sweep(32'd500, 32'd1, 5'd1, 0, 1, 0, 0);
    dw0 = 12'sd7; dw1 = -12'sd2;
    run_sweep(32'd600, 32'd1, 5'd1, 0, 1, 0, 0);

    base = 32'd77; step = 32'd1; npts = 5'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_enable", {63'd0, enable}, 64'd1);
    chk("abort_valid", {63'd0, res_valid}, 64'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_stays_idle", {63'd0, busy}, 64'd0);

    run_sweep(32'd20, 32'hFFFF_FFFC, 5'd0, 0, 0, 0, 0);
    run_sweep(32'd0, 32'hFFFF_FFFF, 5'd2, 1, 0, 0, 0);
    run_sweep(32'd900, 32'd50, 5'd1, 0, 0, 1, 0);
    repeat (15) @(posedge clk);
    #1;
    chk("busy_start_ignored", {63'd0, busy}, 64'd0);
    run_sweep(32'd3000, 32'd100, 5'd3, 0, 0, 0, 1);
    chk("after_reset_busy", {63'd0, busy}, 64'd0);

    for (int r = 0; r < 6; r++) begin
      run_sweep($urandom, $urandom, 5'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 0, 0, 0);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("done_count", 64'(done_seen), 64'(done_exp));
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
